// File: rtl/uart_sys_pkg.sv
// uart_sys_pkg: opcodes, FSM state encoding and operand register addresses shared by the UART system controller.
package uart_sys_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD
    } state_e;

endpackage

// File: rtl/uart_sys_ctrl_tx.sv
// uart_sys_ctrl_tx: registered TX FIFO write port; accepts a byte only when the FIFO has room and
// the previous strobe has dropped, so every tx_wr_en pulse is exactly one cycle wide.
module uart_sys_ctrl_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [DATA_W-1:0] byte_i,
    input  logic              full_i,
    output logic              ack_o,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o
);

    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;

    assign ack_o     = req_i & ~full_i & ~wr_en_q;
    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= ack_o;
            if (ack_o) wr_data_q <= byte_i;
        end
    end

endmodule

// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl: turns received UART frames into register-file and ALU commands and queues the
// responses into the TX FIFO. Define SYS_CTRL_TIMEOUT_EN to abandon commands stalled between frames.
module uart_sys_ctrl
    import uart_sys_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int FUN_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_data_valid,
    input  logic [DATA_W-1:0]   rx_p_data,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic                rf_rd_valid,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_out_valid,
    input  logic                tx_fifo_full,
    output logic                rf_wr_en,
    output logic                rf_rd_en,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic                alu_en,
    output logic [FUN_W-1:0]    alu_fun,
    output logic                tx_wr_en,
    output logic [DATA_W-1:0]   tx_wr_data,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rd_q, rd_d, rf_wr_data_d, tx_byte;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic [ADDR_W-1:0]   rf_addr_d;
    logic [FUN_W-1:0]    alu_fun_d;
    logic                rf_wr_en_d, rf_rd_en_d, alu_en_d, busy_d, tx_req, tx_ack, tmo;
    logic                v;

    assign v = rx_data_valid;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coll;

    // Only byte-collecting states count; any accepted byte restarts the window.
    assign coll  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN};
    assign cnt_d = (coll && !v) ? cnt_q + CW'(1) : '0;
    assign tmo   = coll && !v && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    // A result arriving with FIFO room goes out on the very next edge, skipping its TX state.
    always_comb begin
        tx_req  = 1'b0;
        tx_byte = rd_q;
        case (state_q)
            RD_WAIT:  begin tx_req = rf_rd_valid;   tx_byte = rf_rd_data;              end
            ALU_WAIT: begin tx_req = alu_out_valid; tx_byte = alu_out[DATA_W-1:0];     end
            TX_LSB:   begin tx_req = 1'b1;          tx_byte = res_q[DATA_W-1:0];        end
            TX_MSB:   begin tx_req = 1'b1;          tx_byte = res_q[2*DATA_W-1:DATA_W]; end
            TX_RD:    tx_req = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        res_d        = res_q;
        rf_addr_d    = rf_addr;
        rf_wr_data_d = rf_wr_data;
        alu_fun_d    = alu_fun;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        case (state_q)
            IDLE: if (v) state_d = rx_p_data == DATA_W'(CMD_WR)      ? WR_ADDR :
                                   rx_p_data == DATA_W'(CMD_RD)      ? RD_ADDR :
                                   rx_p_data == DATA_W'(CMD_ALU_OP)  ? OP_A    :
                                   rx_p_data == DATA_W'(CMD_ALU_NOP) ? ALU_FUN : IDLE;
            WR_ADDR: if (v) begin
                rf_addr_d = rx_p_data[ADDR_W-1:0];
                state_d   = WR_DATA;
            end
            WR_DATA: if (v) begin
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = IDLE;
            end
            RD_ADDR: if (v) begin
                rf_addr_d  = rx_p_data[ADDR_W-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: if (rf_rd_valid) begin
                rd_d    = rf_rd_data;
                state_d = tx_ack ? IDLE : TX_RD;
            end
            OP_A: if (v) begin
                rf_addr_d    = ADDR_W'(OPA_ADDR);
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = OP_B;
            end
            OP_B: if (v) begin
                rf_addr_d    = ADDR_W'(OPB_ADDR);
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ALU_FUN;
            end
            ALU_FUN: if (v) begin
                alu_fun_d = rx_p_data[FUN_W-1:0];
                alu_en_d  = 1'b1;
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: if (alu_out_valid) begin
                res_d   = alu_out;
                state_d = tx_ack ? TX_MSB : TX_LSB;
            end
            TX_LSB:  if (tx_ack) state_d = TX_MSB;
            TX_MSB:  if (tx_ack) state_d = IDLE;
            TX_RD:   if (tx_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo) state_d = IDLE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            res_q      <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            rf_wr_en   <= rf_wr_en_d;
            rf_rd_en   <= rf_rd_en_d;
            rf_addr    <= rf_addr_d;
            rf_wr_data <= rf_wr_data_d;
            alu_en     <= alu_en_d;
            alu_fun    <= alu_fun_d;
            busy       <= busy_d;
        end
    end

    uart_sys_ctrl_tx #(.DATA_W(DATA_W)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .req_i     (tx_req),
        .byte_i    (tx_byte),
        .full_i    (tx_fifo_full),
        .ack_o     (tx_ack),
        .wr_en_o   (tx_wr_en),
        .wr_data_o (tx_wr_data)
    );

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb_uart_sys_ctrl: directed command frames against uart_sys_ctrl with hand-computed expectations.
module tb_uart_sys_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_p_data = '0;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        tx_fifo_full = 1'b0;
    logic        rf_wr_en, rf_rd_en, alu_en, tx_wr_en, busy;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, tx_wr_data;

    int checks = 0;
    int errors = 0;
    int dbl = 0;
    int rd_n = 0;
    int alu_n = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic [3:0]  prev = '0;
    logic [28:0] outs;

    always #5 clk = ~clk;

    uart_sys_ctrl #(.TIMEOUT_CYCLES(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_p_data     (rx_p_data),
        .rf_rd_data    (rf_rd_data),
        .rf_rd_valid   (rf_rd_valid),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .tx_fifo_full  (tx_fifo_full),
        .rf_wr_en      (rf_wr_en),
        .rf_rd_en      (rf_rd_en),
        .rf_addr       (rf_addr),
        .rf_wr_data    (rf_wr_data),
        .alu_en        (alu_en),
        .alu_fun       (alu_fun),
        .tx_wr_en      (tx_wr_en),
        .tx_wr_data    (tx_wr_data),
        .busy          (busy)
    );

    assign outs = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_wr_en, tx_wr_data, busy};

    always @(negedge clk) begin
        if (rst) begin
            if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
            if (tx_wr_en) tx_q.push_back(tx_wr_data);
            if (rf_rd_en) rd_n++;
            if (alu_en) alu_n++;
            if (({rf_wr_en, rf_rd_en, alu_en, tx_wr_en} & prev) != 4'd0) dbl++;
            prev = {rf_wr_en, rf_rd_en, alu_en, tx_wr_en};
        end else prev = '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data_valid = 1'b1;
        rx_p_data     = b;
        @(posedge clk);
        #1 rx_data_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b);
        send(b);
        idle(3);
    endtask

    task automatic rd_pulse(input logic [7:0] d);
        rf_rd_data  = d;
        rf_rd_valid = 1'b1;
        @(posedge clk);
        #1 rf_rd_valid = 1'b0;
    endtask

    task automatic alu_pulse(input logic [15:0] r);
        alu_out       = r;
        alu_out_valid = 1'b1;
        @(posedge clk);
        #1 alu_out_valid = 1'b0;
        alu_out = 16'hFFFF;
    endtask

    initial begin
        idle(3);
        check("reset_outs", {3'd0, outs}, 32'd0);
        rst = 1'b1;
        idle(2);
        check("post_reset_outs", {3'd0, outs}, 32'd0);

        frame(8'hAA); frame(8'h05); send(8'h3C);
        check("wr_latency", rf_wr_en, 1);
        idle(4);
        check("wr_count", wr_q.size(), 1);
        check("wr_addr_data", wr_q[0], 12'h53C);
        check("wr_busy_low", busy, 0);
        wr_q.delete();

        frame(8'hBB); send(8'h07);
        check("rd_en", {rf_rd_en, rf_addr}, 5'h17);
        idle(3);
        check("rd_wait_busy", busy, 1);
        rd_pulse(8'h99);
        check("rd_tx_latency", {tx_wr_en, tx_wr_data}, 9'h199);
        idle(5);
        check("rd_tx_count", tx_q.size(), 1);
        check("rd_tx_byte", tx_q[0], 8'h99);
        check("rd_en_count", rd_n, 1);
        tx_q.delete();

        frame(8'hCC); frame(8'h10); frame(8'h20); send(8'h00);
        check("alu_en_fun", {alu_en, alu_fun}, 5'h10);
        check("op_wr_count", wr_q.size(), 2);
        check("opa_write", wr_q[0], 12'h010);
        check("opb_write", wr_q[1], 12'h120);
        idle(2);
        alu_pulse(16'h0030);
        idle(8);
        check("alu_tx_count", tx_q.size(), 2);
        check("alu_tx_lsb", tx_q[0], 8'h30);
        check("alu_tx_msb", tx_q[1], 8'h00);
        check("alu_busy_low", busy, 0);
        wr_q.delete(); tx_q.delete();

        frame(8'hDD); send(8'h02);
        check("nop_alu_fun", {alu_en, alu_fun}, 5'h12);
        idle(2);
        tx_fifo_full = 1'b1;
        alu_pulse(16'hBEEF);
        idle(4);
        check("full_holdoff", tx_q.size(), 0);
        check("full_busy", busy, 1);
        tx_fifo_full = 1'b0;
        idle(8);
        check("full_tx_count", tx_q.size(), 2);
        check("full_tx_lsb", tx_q[0], 8'hEF);
        check("full_tx_msb", tx_q[1], 8'hBE);
        check("alu_en_count", alu_n, 2);
        tx_q.delete();

        frame(8'h55);
        check("unknown_busy", busy, 0);
        frame(8'hAA); frame(8'h01); frame(8'h02);
        check("after_unknown_wr", wr_q.size(), 1);
        check("after_unknown_data", wr_q[0], 12'h102);
        wr_q.delete();

        rd_pulse(8'h77);
        alu_pulse(16'h1234);
        idle(4);
        check("stray_valid_tx", tx_q.size(), 0);
        frame(8'hBB); frame(8'h04); frame(8'hAA);
        rd_pulse(8'h5A);
        idle(5);
        check("rd_drop_tx", tx_q.size(), 1);
        check("rd_drop_byte", tx_q[0], 8'h5A);
        check("rd_drop_busy", busy, 0);
        tx_q.delete();

        frame(8'hAA); frame(8'h03);
        idle(100);
        check("silence_no_wr", wr_q.size(), 0);
`ifdef SYS_CTRL_TIMEOUT_EN
        check("timeout_busy", busy, 0);
`else
        check("no_timeout_busy", busy, 1);
`endif
        rst = 1'b0;
        #1 check("rst_outs", {3'd0, outs}, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(2);

        frame(8'hCC); frame(8'h11);
        check("mid_cc_wr", wr_q.size(), 1);
        check("mid_cc_data", wr_q[0], 12'h011);
        #2 rst = 1'b0;
        #1 check("mid_cc_rst_outs", {3'd0, outs}, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(3);
        frame(8'h22);
        check("mid_cc_abandoned", wr_q.size(), 1);
        check("mid_cc_busy", busy, 0);

        check("strobe_width", dbl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
